axis_frame_sequencer: RTL and testbench
=======================================

# axis_frame_sequencer

- Frame-level controller that sequences line loads into the AXI4-Stream output line buffer.
- Waits for the upscaler to report a completed line, then pulses the buffer's load strobe.
- Counts `tlast` handshakes on the output stream to detect line completion, then acknowledges the line back upstream.
- Tracks line position within the frame, flags start-of-frame, and reports frame completion and protocol errors.

## Interface
- `LINES_PER_FRAME`, 720: lines per frame; must be at least 1.
- `TXNS_PER_LINE`, 1: `tlast`-terminated transactions per line; must be at least 1.
- `CNT_W`, 16: width of the line and transaction counters.
- `aclk` in 1: sole clock; all logic on the rising edge.
- `areset` in 1: synchronous, active-low reset.
- `enable` in 1: permits a new frame to start; sampled only at a frame boundary.
- `line_avail` in 1: level; upstream holds a complete line ready for loading.
- `line_ack` out 1: one-cycle pulse; the current line has been fully transmitted.
- `buf_load` out 1: one-cycle pulse; drives the output buffer's load-valid input.
- `m_tvalid` in 1: tap of the output stream `tvalid`.
- `m_tready` in 1: tap of the output stream `tready`.
- `m_tlast` in 1: tap of the output stream `tlast`.
- `tuser` out 1: start-of-frame marker, aligned to the output stream.
- `frame_done` out 1: one-cycle pulse after the last line of a frame is acknowledged.
- `line_idx` out CNT_W: index of the line currently loaded or pending.
- `busy` out 1: high in any state other than IDLE.
- `err` out 1: sticky protocol error flag.
- `state_probe` out 8: current state encoding.

## Operation
- State encodings: IDLE=0, LOAD=1, WAIT_TX=2, ACK=3.
- **IDLE**
  - If `line_idx`==0, require `enable`=1 and `line_avail`=1; otherwise require `line_avail`=1 only.
  - When the condition holds, go to LOAD.
  - Entering LOAD with `line_idx`==0 sets `sof_pending`.
- **LOAD**
  - `buf_load`=1 for exactly this cycle.
  - Clear `txn_cnt`, then go to WAIT_TX unconditionally.
- **WAIT_TX**
  - Each cycle with `m_tvalid` & `m_tready` & `m_tlast` increments `txn_cnt`.
  - When the increment brings `txn_cnt` to TXNS_PER_LINE, go to ACK.
- **ACK**
  - `line_ack`=1 for this cycle, then go to IDLE.
  - If `line_idx`==LINES_PER_FRAME-1: `line_idx` wraps to 0, and `frame_done` pulses in this same cycle.
  - Otherwise `line_idx` increments by 1.
- `sof_pending` clears on the first `m_tvalid` & `m_tready` beat seen after it is set.
- `enable` is ignored mid-frame. A started frame always runs to `frame_done`. Deasserting `enable` stops the sequencer at the next frame boundary.
- `err` is set, and stays set until reset, on either condition:
  - a `m_tvalid` & `m_tready` & `m_tlast` handshake while in IDLE or LOAD;
  - `line_avail` dropping while in LOAD.
- An error does not alter state flow.

## Timing
- Reset values:
  - state=IDLE; `line_idx`=0; `txn_cnt`=0; `sof_pending`=0; `err`=0.
  - `buf_load`, `line_ack`, `frame_done`, `tuser` and `busy` are all 0.
- Reset applies at any point mid-frame and abandons the frame. The next frame restarts at line 0.
- `line_avail` sampled high in IDLE puts `buf_load` high on the next cycle (1-cycle latency).
- A qualifying `tlast` handshake in WAIT_TX produces `line_ack` on the next cycle.
- Minimum spacing between consecutive `buf_load` pulses is 4 cycles.
- `tuser` is combinational: `tuser = sof_pending & m_tvalid`. It is therefore valid in the same cycle as the first beat of the frame.
- Simultaneous `frame_done` and `enable`=0 leaves the block in IDLE with `line_idx`=0.
- A handshake on the cycle that leaves WAIT_TX is the completing one and is not flagged as an error.
- Counters are CNT_W bits wide. `line_idx` never exceeds LINES_PER_FRAME-1.

## Configuration
- `FRAME_SEQ_WATCHDOG_EN`
  - Defined: a 16-bit counter runs in WAIT_TX, incrementing each cycle and clearing on any `m_tvalid` & `m_tready` beat.
  - On reaching 0xFFFF it sets `err` and forces state to ACK, so the line is acknowledged and the frame proceeds.
  - Not defined: no watchdog. WAIT_TX waits indefinitely.

## Test plan
- LINES_PER_FRAME=3, TXNS_PER_LINE=1, `enable`=1, `line_avail` held high, one `tlast` handshake 5 cycles after each `buf_load` -> 3 `buf_load` pulses, 3 `line_ack` pulses, `line_idx` goes 0,1,2,0, and one `frame_done` coincident with the 3rd `line_ack`.
- TXNS_PER_LINE=2 -> `line_ack` pulses only on the cycle after the 2nd `tlast` handshake; the 1st `tlast` produces no ack.
- `enable` dropped after line 0 is loaded (LINES_PER_FRAME=3) -> lines 1 and 2 still complete with `frame_done`; the block then holds IDLE with `busy`=0 despite `line_avail`=1.
- First beat of a frame stalled (`m_tvalid`=1, `m_tready`=0) for 3 cycles -> `tuser`=1 across all 3 cycles and the accepting cycle, then `tuser`=0 for the remaining beats.
- `tlast` handshake injected in IDLE -> `err`=1 and stays 1. `areset`=0 for one cycle mid-WAIT_TX -> state=IDLE, `line_idx`=0, `err`=0.
- With `FRAME_SEQ_WATCHDOG_EN` defined, no beats for 65535 cycles in WAIT_TX -> `err`=1 and `line_ack` on the following cycle.

Source files
------------

// File: rtl/axis_frame_sequencer.sv
// axis_frame_sequencer: sequences line loads into an AXI4-Stream output line
// buffer. It waits for a complete line upstream, pulses buf_load, counts
// tlast handshakes on the output stream, then acknowledges the line back
// upstream. It also tracks the line index within the frame, marks
// start-of-frame on tuser, and flags protocol errors.
//
// Optional feature macro: FRAME_SEQ_WATCHDOG_EN. When it is defined, a
// 16-bit stall watchdog in WAIT_TX sets err and forces the line to ACK.
//
// Handshake note: a beat is a cycle with m_tvalid & m_tready both high. A
// line-completing beat also has m_tlast high. The m_* inputs are passive
// taps only; this block never drives the stream.
module axis_frame_sequencer #(
  parameter int LINES_PER_FRAME = 720,
  parameter int TXNS_PER_LINE   = 1,
  parameter int CNT_W           = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             enable,
  input  logic             line_avail,
  output logic             line_ack,
  output logic             buf_load,
  input  logic             m_tvalid,
  input  logic             m_tready,
  input  logic             m_tlast,
  output logic             tuser,
  output logic             frame_done,
  output logic [CNT_W-1:0] line_idx,
  output logic             busy,
  output logic             err,
  output logic [7:0]       state_probe
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_TX = 2'd2,
    ACK     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_LINE  = CNT_W'(LINES_PER_FRAME - 1);
  localparam logic [CNT_W-1:0] TXN_TARGET = CNT_W'(TXNS_PER_LINE);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] line_idx_q, line_idx_d;
  logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;
  logic             sof_q, sof_d;
  logic             err_q, err_d;
  logic             buf_load_q, buf_load_d;
  logic             line_ack_q, line_ack_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic             beat, beat_last;
`ifdef FRAME_SEQ_WATCHDOG_EN
  logic [15:0]      wdog_q, wdog_d;
`endif

  assign beat      = m_tvalid & m_tready;
  assign beat_last = beat & m_tlast;

  // Next-state, counter, flag and registered-output computation.
  always_comb begin
    state_d    = state_q;
    line_idx_d = line_idx_q;
    txn_cnt_d  = txn_cnt_q;
    sof_d      = sof_q;
    err_d      = err_q;
`ifdef FRAME_SEQ_WATCHDOG_EN
    wdog_d     = '0;
`endif
    // The first accepted beat after start-of-frame retires the marker.
    if (sof_q && beat) sof_d = 1'b0;

    case (state_q)
      IDLE: begin
        // enable only matters at line 0, which is the frame boundary.
        if (line_avail && ((line_idx_q != '0) || enable)) begin
          state_d = LOAD;
          if (line_idx_q == '0) sof_d = 1'b1;
        end
      end
      LOAD: begin
        txn_cnt_d = '0;
        state_d   = WAIT_TX;
      end
      WAIT_TX: begin
        if (beat_last) begin
          txn_cnt_d = txn_cnt_q + CNT_W'(1);
          if (txn_cnt_d == TXN_TARGET) state_d = ACK;
        end
`ifdef FRAME_SEQ_WATCHDOG_EN
        wdog_d = beat ? 16'h0000 : (wdog_q + 16'h0001);
        if (wdog_d == 16'hFFFF) begin
          err_d   = 1'b1;
          state_d = ACK;
        end
`endif
      end
      ACK: begin
        state_d    = IDLE;
        line_idx_d = (line_idx_q == LAST_LINE) ? '0 : (line_idx_q + CNT_W'(1));
      end
      default: state_d = IDLE;
    endcase

    // A tlast beat outside WAIT_TX means the stream ran ahead of the
    // sequencer. A line that vanishes during LOAD was loaded too early.
    if (beat_last && ((state_q == IDLE) || (state_q == LOAD))) err_d = 1'b1;
    if ((state_q == LOAD) && !line_avail) err_d = 1'b1;

    buf_load_d   = (state_d == LOAD);
    line_ack_d   = (state_d == ACK);
    frame_done_d = (state_d == ACK) && (line_idx_q == LAST_LINE);
    busy_d       = (state_d != IDLE);
  end

  // State and output registers with a synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!areset) begin
      state_q      <= IDLE;
      line_idx_q   <= '0;
      txn_cnt_q    <= '0;
      sof_q        <= 1'b0;
      err_q        <= 1'b0;
      buf_load_q   <= 1'b0;
      line_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef FRAME_SEQ_WATCHDOG_EN
      wdog_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      line_idx_q   <= line_idx_d;
      txn_cnt_q    <= txn_cnt_d;
      sof_q        <= sof_d;
      err_q        <= err_d;
      buf_load_q   <= buf_load_d;
      line_ack_q   <= line_ack_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
`ifdef FRAME_SEQ_WATCHDOG_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

  assign buf_load    = buf_load_q;
  assign line_ack    = line_ack_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign line_idx    = line_idx_q;
  assign tuser       = sof_q & m_tvalid;
  assign state_probe = {6'b000000, state_q};

endmodule

// File: tb/tb_axis_frame_sequencer.sv
// Testbench for axis_frame_sequencer (3 lines per frame, 2 tlast
// transactions per line).
module tb_axis_frame_sequencer;

  localparam int LPF   = 3;
  localparam int TXN   = 2;
  localparam int CNT_W = 16;

  logic             aclk, areset, enable, line_avail;
  logic             line_ack, buf_load, m_tvalid, m_tready, m_tlast;
  logic             tuser, frame_done, busy, err;
  logic [CNT_W-1:0] line_idx;
  logic [7:0]       state_probe;

  axis_frame_sequencer #(
    .LINES_PER_FRAME(LPF),
    .TXNS_PER_LINE  (TXN),
    .CNT_W          (CNT_W)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .enable     (enable),
    .line_avail (line_avail),
    .line_ack   (line_ack),
    .buf_load   (buf_load),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .tuser      (tuser),
    .frame_done (frame_done),
    .line_idx   (line_idx),
    .busy       (busy),
    .err        (err),
    .state_probe(state_probe)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  // Each entry is {frame_done expected, line_idx expected} for one line_ack.
  logic [CNT_W:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int load_cnt = 0;
  int exp_loads = 0;
  int last_load_cyc = -1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: pops one expected entry per line_ack and checks load spacing.
  always @(negedge aclk) begin
    if (areset) begin
      if (buf_load) begin
        load_cnt++;
        if (last_load_cyc >= 0)
          check_val("load_spacing_ge4", 32'((cyc - last_load_cyc) >= 4), 32'd1);
        last_load_cyc = cyc;
      end
      if (line_ack) begin
        check_val("ack_was_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [CNT_W:0] e;
          e = exp_q.pop_front();
          check_val("ack_line_idx", 32'(line_idx), 32'(e[CNT_W-1:0]));
          check_val("ack_frame_done", 32'(frame_done), 32'(e[CNT_W]));
        end
      end else if (frame_done) begin
        check_val("frame_done_with_ack", 32'(line_ack), 32'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_load(input int idx);
    int n;
    n = 0;
    exp_loads++;
    do begin
      @(negedge aclk);
      n++;
    end while (!buf_load && n < 40);
    check_val("load_seen", 32'(buf_load), 32'd1);
    check_val("load_line_idx", 32'(line_idx), 32'(idx));
    check_val("load_state", 32'(state_probe), 32'd1);
  endtask

  task automatic send_beat(input logic last, input logic push, input logic [CNT_W:0] e);
    m_tvalid = 1'b1;
    m_tready = 1'b1;
    m_tlast  = last;
    if (push) exp_q.push_back(e);
    @(posedge aclk);
    #1;
    m_tvalid = 1'b0;
    m_tready = 1'b0;
    m_tlast  = 1'b0;
  endtask

  // Completes a loaded line: gap cycles of silence, then TXN tlast beats.
  task automatic finish_line(input int gap, input int idx);
    logic [CNT_W:0] e;
    e = {(idx == LPF - 1), CNT_W'(idx)};
    repeat (gap) @(posedge aclk);
    #1;
    send_beat(1'b1, 1'b0, e);
    @(negedge aclk);
    check_val("no_ack_after_first_tlast", 32'(line_ack), 32'd0);
    check_val("still_wait_tx", 32'(state_probe), 32'd2);
    @(posedge aclk);
    #1;
    send_beat(1'b1, 1'b1, e);
    @(negedge aclk);
    check_val("ack_latency", 32'(line_ack), 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge aclk);
    #1;
    areset = 1'b0;
    exp_q.delete();
    @(posedge aclk);
    #1;
    areset = 1'b1;
    last_load_cyc = -1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    areset = 1'b0; enable = 1'b0; line_avail = 1'b0;
    m_tvalid = 1'b1; m_tready = 1'b0; m_tlast = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_val("rst_state", 32'(state_probe), 32'd0);
    check_val("rst_line_idx", 32'(line_idx), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_buf_load", 32'(buf_load), 32'd0);
    check_val("rst_line_ack", 32'(line_ack), 32'd0);
    check_val("rst_frame_done", 32'(frame_done), 32'd0);
    check_val("rst_tuser", 32'(tuser), 32'd0);
    @(posedge aclk);
    #1;
    areset = 1'b1;
    m_tvalid = 1'b0;

    // Line available but enable low at line 0: no frame starts.
    line_avail = 1'b1;
    repeat (4) @(negedge aclk);
    check_val("no_start_without_enable", 32'(busy), 32'd0);

    // Frame A: line 0 with a stalled first beat, then lines 1 and 2.
    @(posedge aclk);
    #1;
    enable = 1'b1;
    wait_load(0);
    @(posedge aclk);
    #1;
    m_tvalid = 1'b1; m_tready = 1'b0; m_tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check_val("tuser_stalled", 32'(tuser), 32'd1);
      @(posedge aclk);
      #1;
    end
    m_tready = 1'b1;
    @(negedge aclk);
    check_val("tuser_accept", 32'(tuser), 32'd1);
    @(posedge aclk);
    #1;
    @(negedge aclk);
    check_val("tuser_after_first", 32'(tuser), 32'd0);
    @(posedge aclk);
    #1;
    m_tvalid = 1'b0; m_tready = 1'b0;
    @(negedge aclk);
    finish_line(1, 0);
    for (int l = 1; l < LPF; l++) begin
      wait_load(l);
      finish_line(5, l);
    end
    @(negedge aclk);
    check_val("wrap_line_idx", 32'(line_idx), 32'd0);

    // Frame B: enable dropped right after line 0 loads; frame still ends.
    wait_load(0);
    enable = 1'b0;
    finish_line(1, 0);
    for (int l = 1; l < LPF; l++) begin
      wait_load(l);
      finish_line(1 + $urandom_range(0, 3), l);
    end
    repeat (10) @(negedge aclk);
    check_val("stopped_busy", 32'(busy), 32'd0);
    check_val("stopped_state", 32'(state_probe), 32'd0);
    check_val("stopped_line_idx", 32'(line_idx), 32'd0);
    check_val("stopped_load_count", 32'(load_cnt), 32'(exp_loads));

    // tlast handshake in IDLE sets a sticky error.
    @(posedge aclk);
    #1;
    line_avail = 1'b0;
    send_beat(1'b1, 1'b0, '0);
    @(negedge aclk);
    check_val("err_idle_tlast", 32'(err), 32'd1);
    repeat (5) @(negedge aclk);
    check_val("err_sticky", 32'(err), 32'd1);
    pulse_reset();
    @(negedge aclk);
    check_val("err_cleared_by_reset", 32'(err), 32'd0);

    // Reset in the middle of WAIT_TX on line 1 abandons the frame.
    @(posedge aclk);
    #1;
    enable = 1'b1; line_avail = 1'b1;
    wait_load(0);
    finish_line(1, 0);
    wait_load(1);
    @(posedge aclk);
    #1;
    send_beat(1'b1, 1'b0, '0);
    @(negedge aclk);
    check_val("pre_reset_wait_tx", 32'(state_probe), 32'd2);
    line_avail = 1'b0;
    pulse_reset();
    @(negedge aclk);
    check_val("mid_rst_state", 32'(state_probe), 32'd0);
    check_val("mid_rst_line_idx", 32'(line_idx), 32'd0);
    check_val("mid_rst_err", 32'(err), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);

    // line_avail drops while in LOAD: error, but the line still runs.
    @(posedge aclk);
    #1;
    line_avail = 1'b1;
    @(posedge aclk);
    #1;
    line_avail = 1'b0;
    exp_loads++;
    @(negedge aclk);
    check_val("drop_load_pulse", 32'(buf_load), 32'd1);
    check_val("drop_err_not_yet", 32'(err), 32'd0);
    @(negedge aclk);
    check_val("drop_err", 32'(err), 32'd1);
    check_val("drop_flow_kept", 32'(state_probe), 32'd2);
    finish_line(1, 0);
    enable = 1'b0;
    repeat (4) @(negedge aclk);
    check_val("final_line_idx", 32'(line_idx), 32'd1);
    check_val("final_queue_drained", 32'(exp_q.size()), 32'd0);
    check_val("final_load_count", 32'(load_cnt), 32'(exp_loads));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #500000;
    n_cmp++;
    n_err++;
    $display("FAIL timeout: got still running expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
